// File: rtl/alu.sv
// Registered 32-bit execute-stage ALU with exception-code merge.
// Optional macro ALU_OVERFLOW_EXC_EN enables signed ADD/SUB overflow -> Ov (12).
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [2:0]  ALUop,
  input  logic [5:0]  ExcCodeA,
  output logic [31:0] result,
  output logic [5:0]  ExcCodeE
);

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 3;
  localparam int unsigned EW  = 6;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_OR   = OPW'(2);
  localparam logic [OPW-1:0] OP_AND  = OPW'(3);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(4);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(5);
  localparam logic [OPW-1:0] OP_LUI  = OPW'(6);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(7);

  logic [DW-1:0] sum_c;
  logic [DW-1:0] diff_c;
  logic [DW-1:0] res_c;
  logic [EW-1:0] exc_c;

  assign sum_c  = rs + rt;
  assign diff_c = rs - rt;

  // Operation select; ADD/SUB always produce the wrapped value.
  always_comb begin
    res_c = '0;
    case (ALUop)
      OP_ADD:  res_c = sum_c;
      OP_SUB:  res_c = diff_c;
      OP_OR:   res_c = rs | rt;
      OP_AND:  res_c = rs & rt;
      OP_SLT:  res_c = DW'($signed(rs) < $signed(rt));
      OP_SLTU: res_c = DW'(rs < rt);
      OP_LUI:  res_c = {rt[15:0], 16'h0000};
      OP_XOR:  res_c = rs ^ rt;
      default: res_c = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EXC_EN
  localparam logic [EW-1:0] EXC_OV = EW'(12);
  logic ovf_c;

  // Earlier-stage exceptions take priority over a local overflow.
  always_comb begin
    ovf_c = 1'b0;
    exc_c = ExcCodeA;
    if (ALUop == OP_ADD)
      ovf_c = (rs[DW-1] == rt[DW-1]) && (sum_c[DW-1] != rs[DW-1]);
    else if (ALUop == OP_SUB)
      ovf_c = (rs[DW-1] != rt[DW-1]) && (diff_c[DW-1] != rs[DW-1]);
    if (ExcCodeA == '0)
      exc_c = ovf_c ? EXC_OV : '0;
  end
`else
  assign exc_c = ExcCodeA;
`endif

  // EX/MEM boundary registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= '0;
      ExcCodeE <= '0;
    end else begin
      result   <= res_c;
      ExcCodeE <= exc_c;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed steps, expected values queued at drive
// time and compared one edge later.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [2:0]  ALUop;
  logic [5:0]  ExcCodeA;
  logic [31:0] result;
  logic [5:0]  ExcCodeE;

  typedef struct {
    string       tag;
    logic [31:0] r;
    logic [5:0]  e;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  alu dut (
    .clk      (clk),
    .reset    (reset),
    .rs       (rs),
    .rt       (rt),
    .ALUop    (ALUop),
    .ExcCodeA (ExcCodeA),
    .result   (result),
    .ExcCodeE (ExcCodeE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: overflow judged from 64-bit signed arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op, input logic [5:0] ea,
                                output logic [31:0] r, output logic [5:0] e);
    longint sa, sb64, wide;
    logic   ov;
    sa   = longint'($signed(a));
    sb64 = longint'($signed(b));
    wide = 0;
    ov   = 1'b0;
    case (op)
      3'd0: begin wide = sa + sb64; r = a + b; end
      3'd1: begin wide = sa - sb64; r = a - b; end
      3'd2: r = a | b;
      3'd3: r = a & b;
      3'd4: r = (sa < sb64) ? 32'd1 : 32'd0;
      3'd5: r = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      3'd6: r = {b[15:0], 16'h0000};
      default: r = a ^ b;
    endcase
    if (op == 3'd0 || op == 3'd1)
      ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
`ifdef ALU_OVERFLOW_EXC_EN
    e = (ea != 6'd0) ? ea : (ov ? 6'd12 : 6'd0);
`else
    e = ea;
    if (ov) e = ea;
`endif
  endfunction

  // One cycle: drive at negedge, queue expectation, compare after next posedge.
  task automatic step(input string tag, input logic rst, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] op,
                      input logic [5:0] ea);
    exp_t x;
    @(negedge clk);
    reset = rst; rs = a; rt = b; ALUop = op; ExcCodeA = ea;
    x.tag = tag;
    if (rst) begin
      x.r = 32'h0; x.e = 6'h0;
    end else begin
      model(a, b, op, ea, x.r, x.e);
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL %s scoreboard empty size=%0d required>0", tag, sb.size());
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      checks++;
      assert (result === x.r) else begin
        failures++;
        $error("FAIL %s result=%h expected=%h", x.tag, result, x.r);
      end
      checks++;
      assert (ExcCodeE === x.e) else begin
        failures++;
        $error("FAIL %s ExcCodeE=%0d expected=%0d", x.tag, ExcCodeE, x.e);
      end
    end
  endtask

  logic [5:0] ov_code;

  initial begin
    reset = 1'b1; rs = '0; rt = '0; ALUop = '0; ExcCodeA = '0;
`ifdef ALU_OVERFLOW_EXC_EN
    ov_code = 6'd12;
`else
    ov_code = 6'd0;
`endif

    step("reset0", 1'b1, 32'hDEADBEEF, 32'h12345678, 3'd0, 6'd5);
    step("reset1", 1'b1, 32'h7FFFFFFF, 32'h00000001, 3'd0, 6'd3);

    step("add",  1'b0, 32'h0000457C, 32'hFFFFFEEC, 3'd0, 6'd0);
    checks++;
    assert (result === 32'h00004468) else begin
      failures++;
      $error("FAIL add_const result=%h expected=%h", result, 32'h00004468);
    end
    step("sub",  1'b0, 32'h0000457C, 32'hFFFFFEEC, 3'd1, 6'd0);
    checks++;
    assert (result === 32'h00004690) else begin
      failures++;
      $error("FAIL sub_const result=%h expected=%h", result, 32'h00004690);
    end

    step("or",   1'b0, 32'hFFFFFFFB, 32'h00000002, 3'd2, 6'd0);
    step("slt",  1'b0, 32'hFFFFFFFB, 32'h00000002, 3'd4, 6'd0);
    checks++;
    assert (result === 32'd1) else begin
      failures++;
      $error("FAIL slt_const result=%h expected=%h", result, 32'd1);
    end
    step("sltu", 1'b0, 32'hFFFFFFFB, 32'h00000002, 3'd5, 6'd0);
    step("lui",  1'b0, 32'hFFFFFFFB, 32'h00000002, 3'd6, 6'd0);
    checks++;
    assert (result === 32'h00020000) else begin
      failures++;
      $error("FAIL lui_const result=%h expected=%h", result, 32'h00020000);
    end

    step("add_ov",     1'b0, 32'h7FFFFFFF, 32'h00000001, 3'd0, 6'd0);
    checks++;
    assert (ExcCodeE === ov_code && result === 32'h80000000) else begin
      failures++;
      $error("FAIL add_ov_const result=%h exc=%0d expected=80000000/%0d",
             result, ExcCodeE, ov_code);
    end
    step("add_ov_exc", 1'b0, 32'h7FFFFFFF, 32'h00000001, 3'd0, 6'd4);
    step("sub_ov",     1'b0, 32'h80000000, 32'h00000001, 3'd1, 6'd0);
    step("sub_nov",    1'b0, 32'h80000000, 32'h80000000, 3'd1, 6'd0);
    step("add_negov",  1'b0, 32'h80000000, 32'hFFFFFFFF, 3'd0, 6'd0);
    step("slt_edge",   1'b0, 32'h7FFFFFFF, 32'h80000000, 3'd4, 6'd0);
    step("sltu_edge",  1'b0, 32'h7FFFFFFF, 32'h80000000, 3'd5, 6'd0);
    step("and",        1'b0, 32'hF0F0A5A5, 32'h0FF0FFFF, 3'd3, 6'd0);
    step("xor",        1'b0, 32'hF0F0A5A5, 32'h0FF0FFFF, 3'd7, 6'd2);

    // Back-to-back across all opcodes with a reset in the middle cycle.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("b2b_op%0d", i), (i == 4), 32'h80000000 + 32'(i * 32'h1357),
           32'h7FFFFFF0 - 32'(i * 32'h0246), 3'(i), (i == 6) ? 6'd9 : 6'd0);
    end
    step("post_reset", 1'b0, 32'h00000010, 32'h00000020, 3'd0, 6'd0);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain size=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
